// File: rtl/bsg_dfi_to_fifo_sync.sv
// bsg_dfi_to_fifo_sync_fifo: small valid/ready queue, power-of-two depth.
// Latency: a push is visible on o_vld the cycle after it is accepted.
// Backpressure: output holds while o_vld & ~i_rdy; a push while full is dropped.
// Ports: i_clk/i_rst_n (sync, active-low), i_push/i_dat in, o_full,
//        o_vld/o_dat/i_rdy out side. o_dat reads 0 while empty.
module bsg_dfi_to_fifo_sync_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [width_p-1:0] i_dat,
  output logic               o_full,
  output logic               o_vld,
  output logic [width_p-1:0] o_dat,
  input  logic               i_rdy
);
  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wr_ptr;
  logic [ptr_w_lp-1:0] r_rd_ptr;
  logic [ptr_w_lp:0]   r_cnt;
  logic                w_push;
  logic                w_pop;

  assign o_full = (r_cnt == (ptr_w_lp+1)'(els_p));
  assign o_vld  = (r_cnt != '0);
  assign o_dat  = o_vld ? r_mem[r_rd_ptr] : '0;
  // Full is judged on the registered count, so a same-cycle pop never
  // rescues a push into a full queue.
  assign w_push = i_push & ~o_full;
  assign w_pop  = o_vld & i_rdy;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// bsg_dfi_to_fifo_sync: DFI command/write/read bridge onto FIFO-style ports.
// Latency: cmd and packed write word 1 cycle; read data rd_latency_p after rddata_en.
// Backpressure: cmd/write queues hold under ~ready and drop on overflow (sticky error).
// Ports: clk_i/reset_n_i; dfi_* command, write and read buses; fifo_cmd_* and
//        fifo_wr_* valid/ready outputs; fifo_rd_* valid/yumi input; error_clear_i
//        and fifo_error_o {rd underflow, wr overflow, cmd overflow}.
module bsg_dfi_to_fifo_sync #(
  parameter  int dq_data_width_p = 32,
  parameter  int clk_ratio_p     = 2,
  parameter  int cmd_els_p       = 4,
  parameter  int wr_els_p        = 4,
  parameter  int rd_latency_p    = 2,
  localparam int dq_group_lp     = dq_data_width_p >> 3,
  localparam int beat_w_lp       = 2*dq_data_width_p + 2*dq_group_lp,
  localparam int cmd_w_lp        = 26
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [2:0]                              dfi_bank_i,
  input  logic [15:0]                             dfi_address_i,
  input  logic                                    dfi_cke_i,
  input  logic                                    dfi_cs_n_i,
  input  logic                                    dfi_ras_n_i,
  input  logic                                    dfi_cas_n_i,
  input  logic                                    dfi_we_n_i,
  input  logic                                    dfi_reset_n_i,
  input  logic                                    dfi_odt_i,
  input  logic                                    dfi_wrdata_en_i,
  input  logic [2*dq_data_width_p-1:0]            dfi_wrdata_i,
  input  logic [2*dq_group_lp-1:0]                dfi_wrdata_mask_i,
  input  logic                                    dfi_rddata_en_i,
  output logic [2*dq_data_width_p-1:0]            dfi_rddata_o,
  output logic                                    dfi_rddata_valid_o,
  output logic                                    fifo_cmd_v_o,
  output logic [cmd_w_lp-1:0]                     fifo_cmd_data_o,
  input  logic                                    fifo_cmd_ready_i,
  output logic                                    fifo_wr_v_o,
  output logic [clk_ratio_p*beat_w_lp-1:0]        fifo_wr_data_o,
  input  logic                                    fifo_wr_ready_i,
  input  logic                                    fifo_rd_v_i,
  input  logic [clk_ratio_p*2*dq_data_width_p-1:0] fifo_rd_data_i,
  output logic                                    fifo_rd_yumi_o,
  input  logic                                    error_clear_i,
  output logic [2:0]                              fifo_error_o
);
  localparam int cnt_w_lp  = (clk_ratio_p > 1) ? $clog2(clk_ratio_p) : 1;
  localparam int rd_w_lp   = 2*dq_data_width_p;
  localparam int word_w_lp = clk_ratio_p*beat_w_lp;
  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(clk_ratio_p-1);

  // Command path
  logic                w_cmd_push;
  logic                w_cmd_full;
  logic [cmd_w_lp-1:0] w_cmd_dat;

  assign w_cmd_push = ~dfi_cs_n_i;
  assign w_cmd_dat  = {dfi_bank_i, dfi_address_i, dfi_cke_i, dfi_cs_n_i,
                       dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i, dfi_reset_n_i,
                       dfi_odt_i};

  bsg_dfi_to_fifo_sync_fifo #(.width_p(cmd_w_lp), .els_p(cmd_els_p)) u_cmd_fifo (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_push  (w_cmd_push),
    .i_dat   (w_cmd_dat),
    .o_full  (w_cmd_full),
    .o_vld   (fifo_cmd_v_o),
    .o_dat   (fifo_cmd_data_o),
    .i_rdy   (fifo_cmd_ready_i)
  );

  // Write path: assemble clk_ratio_p beats, push on the last one
  logic [cnt_w_lp-1:0]  r_beat_cnt_w;
  logic [word_w_lp-1:0] r_wr_asm;
  logic [word_w_lp-1:0] w_wr_word;
  logic                 w_wr_push;
  logic                 w_wr_full;

  // The word pushed on the last beat must already contain that beat, so the
  // current beat is merged combinationally rather than through r_wr_asm.
  always_comb begin
    w_wr_word = r_wr_asm;
    w_wr_word[int'(r_beat_cnt_w)*beat_w_lp +: beat_w_lp] = {dfi_wrdata_i, dfi_wrdata_mask_i};
  end

  assign w_wr_push = dfi_wrdata_en_i & (r_beat_cnt_w == last_beat_lp);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_beat_cnt_w <= '0;
      r_wr_asm     <= '0;
    end else if (dfi_wrdata_en_i) begin
      if (r_beat_cnt_w == last_beat_lp) begin
        r_beat_cnt_w <= '0;
        r_wr_asm     <= '0;
      end else begin
        r_beat_cnt_w <= r_beat_cnt_w + 1'b1;
        r_wr_asm     <= w_wr_word;
      end
    end
  end

  bsg_dfi_to_fifo_sync_fifo #(.width_p(word_w_lp), .els_p(wr_els_p)) u_wr_fifo (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_push  (w_wr_push),
    .i_dat   (w_wr_word),
    .o_full  (w_wr_full),
    .o_vld   (fifo_wr_v_o),
    .o_dat   (fifo_wr_data_o),
    .i_rdy   (fifo_wr_ready_i)
  );

  // Read path: latency pipe then unpack one slice per valid beat
  logic [rd_latency_p-1:0] r_rd_sr;
  logic [cnt_w_lp-1:0]     r_beat_cnt_r;
  logic                    w_rd_valid;

  assign w_rd_valid         = r_rd_sr[rd_latency_p-1];
  assign dfi_rddata_valid_o = w_rd_valid;
  assign fifo_rd_yumi_o     = w_rd_valid & fifo_rd_v_i & (r_beat_cnt_r == last_beat_lp);

  always_comb begin
    dfi_rddata_o = '0;
    if (w_rd_valid && fifo_rd_v_i)
      dfi_rddata_o = fifo_rd_data_i[int'(r_beat_cnt_r)*rd_w_lp +: rd_w_lp];
  end

  // The beat counter advances on every valid beat, even on underflow, so a
  // starved burst still leaves the counter aligned to burst boundaries.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_rd_sr      <= '0;
      r_beat_cnt_r <= '0;
    end else begin
      r_rd_sr[0] <= dfi_rddata_en_i;
      for (int i = 1; i < rd_latency_p; i++) r_rd_sr[i] <= r_rd_sr[i-1];
      if (w_rd_valid)
        r_beat_cnt_r <= (r_beat_cnt_r == last_beat_lp) ? '0 : r_beat_cnt_r + 1'b1;
    end
  end

  // Sticky errors; a new event outranks a simultaneous clear
  logic [2:0] r_err;
  logic [2:0] w_err_set;

  assign w_err_set    = {w_rd_valid & ~fifo_rd_v_i, w_wr_push & w_wr_full, w_cmd_push & w_cmd_full};
  assign fifo_error_o = r_err;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) r_err <= '0;
    else            r_err <= (error_clear_i ? 3'b000 : r_err) | w_err_set;
  end
endmodule

// File: tb/tb_bsg_dfi_to_fifo_sync.sv
// tb_bsg_dfi_to_fifo_sync: scoreboard bench for the DFI-to-FIFO bridge.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected cmd/write/read results are queued at drive time and popped as the DUT delivers them.
module tb_bsg_dfi_to_fifo_sync;
  localparam int DQW = 32;
  localparam int RL  = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   bank = 3'd1;
  logic [15:0]  addr = '0;
  logic         cke = 1'b1, cs_n = 1'b1, ras_n = 1'b0, cas_n = 1'b1, we_n = 1'b1;
  logic         dreset_n = 1'b1, odt = 1'b0;
  logic         wren = 1'b0;
  logic [63:0]  wrdata = '0;
  logic [7:0]   wrmask = '0;
  logic         rden = 1'b0;
  logic [63:0]  rddata;
  logic         rdvalid;
  logic         cmd_v;
  logic [25:0]  cmd_data;
  logic         cmd_ready = 1'b0;
  logic         wr_v;
  logic [143:0] wr_data;
  logic         wr_ready = 1'b0;
  logic         rd_v = 1'b0;
  logic [127:0] rd_data = '0;
  logic         yumi;
  logic         err_clear = 1'b0;
  logic [2:0]   err;

  bsg_dfi_to_fifo_sync #(
    .dq_data_width_p(DQW), .clk_ratio_p(2), .cmd_els_p(4), .wr_els_p(4), .rd_latency_p(RL)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .dfi_bank_i(bank), .dfi_address_i(addr), .dfi_cke_i(cke), .dfi_cs_n_i(cs_n),
    .dfi_ras_n_i(ras_n), .dfi_cas_n_i(cas_n), .dfi_we_n_i(we_n),
    .dfi_reset_n_i(dreset_n), .dfi_odt_i(odt),
    .dfi_wrdata_en_i(wren), .dfi_wrdata_i(wrdata), .dfi_wrdata_mask_i(wrmask),
    .dfi_rddata_en_i(rden), .dfi_rddata_o(rddata), .dfi_rddata_valid_o(rdvalid),
    .fifo_cmd_v_o(cmd_v), .fifo_cmd_data_o(cmd_data), .fifo_cmd_ready_i(cmd_ready),
    .fifo_wr_v_o(wr_v), .fifo_wr_data_o(wr_data), .fifo_wr_ready_i(wr_ready),
    .fifo_rd_v_i(rd_v), .fifo_rd_data_i(rd_data), .fifo_rd_yumi_o(yumi),
    .error_clear_i(err_clear), .fifo_error_o(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    logic        y;
    int          c;
  } rd_exp_t;

  logic [25:0]  q_cmd[$];
  logic [143:0] q_wr[$];
  rd_exp_t      q_rd[$];
  rd_exp_t      e;

  function automatic logic [25:0] cmd_word(input logic [15:0] a);
    return {3'd1, a, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (q_cmd.size() == 0) chk("cmd_unexpected", cmd_v, 1'b0);
      else if (cmd_v) begin
        chk("cmd_data", cmd_data, q_cmd[0]);
        if (cmd_ready) void'(q_cmd.pop_front());
      end
      if (q_wr.size() == 0) chk("wr_unexpected", wr_v, 1'b0);
      else if (wr_v) begin
        chk("wr_data", wr_data, q_wr[0]);
        if (wr_ready) void'(q_wr.pop_front());
      end
      if (q_rd.size() == 0) chk("rd_unexpected", rdvalid, 1'b0);
      if (rdvalid && q_rd.size() != 0) begin
        e = q_rd.pop_front();
        chk("rd_data", rddata, e.d);
        chk("rd_yumi", yumi, e.y);
        chk("rd_latency", cyc, e.c);
      end else if (!rdvalid) begin
        chk("rd_idle_data", rddata, 64'h0);
        chk("rd_idle_yumi", yumi, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q_cmd.size() + q_wr.size() + q_rd.size()) != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, q_cmd.size() + q_wr.size() + q_rd.size(), 0);
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] m);
    wren = 1'b1; wrdata = d; wrmask = m;
    tick();
    wren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_cmd_v", cmd_v, 1'b0);
    chk("rst_wr_v", wr_v, 1'b0);
    chk("rst_rdvalid", rdvalid, 1'b0);
    chk("rst_yumi", yumi, 1'b0);
    chk("rst_err", err, 3'b000);
    chk("rst_cmd_data", cmd_data, 26'h0);
    chk("rst_wr_data", wr_data, 144'h0);
    chk("rst_rddata", rddata, 64'h0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();

    // Command stream with backpressure: 4 held, 5th dropped
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cs_n = 1'b0; addr = 16'h10 + 16'(i);
      if (i < 4) q_cmd.push_back(cmd_word(addr));
      tick();
    end
    cs_n = 1'b1;
    chk("cmd_ovf_err", err, 3'b001);
    chk("cmd_full_v", cmd_v, 1'b1);
    repeat (2) tick();
    cmd_ready = 1'b1;
    drain("cmd_drain");
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("cmd_err_clear", err, 3'b000);

    // Back-to-back commands at full rate
    for (int i = 0; i < 3; i++) begin
      cs_n = 1'b0; addr = 16'h100 + 16'(i);
      q_cmd.push_back(cmd_word(addr));
      tick();
    end
    cs_n = 1'b1;
    drain("cmd_stream_drain");

    // Write packing with a gap between beats
    wr_ready = 1'b1;
    q_wr.push_back({64'hB, 8'hF0, 64'hA, 8'h0F});
    beat(64'hA, 8'h0F);
    tick();
    wren = 1'b1; wrdata = 64'hB; wrmask = 8'hF0;
    @(negedge clk);
    chk("wr_v_before", wr_v, 1'b0);
    @(posedge clk); #1;
    wren = 1'b0;
    @(negedge clk);
    chk("wr_v_after", wr_v, 1'b1);
    tick();
    drain("wr_drain");

    // Write overflow: 5 words into a 4-deep queue under backpressure
    wr_ready = 1'b0;
    for (int w = 0; w < 5; w++) begin
      if (w < 4) q_wr.push_back({64'(2*w+1), 8'(w), 64'(2*w), 8'(w)});
      beat(64'(2*w), 8'(w));
      beat(64'(2*w+1), 8'(w));
    end
    tick();
    chk("wr_ovf_err", err, 3'b010);
    wr_ready = 1'b1;
    drain("wr_ovf_drain");
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("wr_err_clear", err, 3'b000);

    // Read return
    rd_v = 1'b1; rd_data = {64'h22, 64'h11};
    rden = 1'b1;
    q_rd.push_back('{d: 64'h11, y: 1'b0, c: cyc + RL});
    tick();
    q_rd.push_back('{d: 64'h22, y: 1'b1, c: cyc + RL});
    tick();
    rden = 1'b0;
    drain("rd_drain");
    repeat (2) tick();
    chk("rd_no_err", err, 3'b000);

    // Read underflow
    rd_v = 1'b0;
    rden = 1'b1;
    q_rd.push_back('{d: 64'h0, y: 1'b0, c: cyc + RL});
    tick();
    q_rd.push_back('{d: 64'h0, y: 1'b0, c: cyc + RL});
    tick();
    rden = 1'b0;
    drain("udf_drain");
    tick();
    chk("udf_err", err, 3'b100);
    tick();
    chk("udf_err_sticky", err, 3'b100);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("udf_err_clear", err, 3'b000);

    // Reset mid-burst
    cmd_ready = 1'b0; rd_v = 1'b1; rd_data = {64'h44, 64'h33};
    cs_n = 1'b0; addr = 16'h77;
    q_cmd.push_back(cmd_word(addr));
    wren = 1'b1; wrdata = 64'h5; wrmask = 8'h55;
    rden = 1'b1;
    tick();
    cs_n = 1'b1; wren = 1'b0; rden = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    q_cmd.delete();
    chk("rstb_cmd_v", cmd_v, 1'b0);
    chk("rstb_err", err, 3'b000);
    for (int i = 0; i < 4; i++) begin
      chk("rstb_wr_v", wr_v, 1'b0);
      chk("rstb_rdvalid", rdvalid, 1'b0);
      tick();
    end
    cmd_ready = 1'b1;
    q_wr.push_back({64'hD, 8'h22, 64'hC, 8'h11});
    beat(64'hC, 8'h11);
    beat(64'hD, 8'h22);
    drain("rstb_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
